// File: rtl/pipe_sequencer_if.sv
// pipe_sequencer_if: hazard information flowing from the pipeline registers
// into the sequencer, and the stage enable / bubble controls flowing back.
// The slave modport is the sequencer's view; master is the datapath's view.
interface pipe_sequencer_if;
    // Hazard inputs observed in ID and EX
    logic [2:0] ifid_reg1_i;
    logic [2:0] ifid_reg2_i;
    logic       ifid_uses_reg2_i;
    logic       ifid_halt_i;
    logic       idex_read_mem_i;
    logic [2:0] idex_regD_i;
    logic       branch_taken_i;
    // Pipeline controls
    logic       pc_we_o;
    logic       ifid_we_o;
    logic       ifid_flush_o;
    logic       idex_flush_o;

    modport master (
        output ifid_reg1_i, ifid_reg2_i, ifid_uses_reg2_i, ifid_halt_i,
               idex_read_mem_i, idex_regD_i, branch_taken_i,
        input  pc_we_o, ifid_we_o, ifid_flush_o, idex_flush_o
    );

    modport slave (
        input  ifid_reg1_i, ifid_reg2_i, ifid_uses_reg2_i, ifid_halt_i,
               idex_read_mem_i, idex_regD_i, branch_taken_i,
        output pc_we_o, ifid_we_o, ifid_flush_o, idex_flush_o
    );
endinterface

// File: rtl/pipe_sequencer.sv
// pipe_sequencer: central pipeline control FSM for the 5-stage 8-bit core.
// Sequences start-up, load-use stalls, taken-branch flushes and halt/drain.
// Optional build macro PIPE_SEQ_PERF_CNT_EN enables the saturating
// performance counters; without it the counter outputs are tied to zero.
module pipe_sequencer #(
    parameter int BR_PENALTY = 1,   // extra flush cycles after a taken branch (1..7)
    parameter int DRAIN_CYC  = 3,   // cycles from the halt cycle to halted_o (1..7)
    parameter int CNT_W      = 16   // performance counter width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    pipe_sequencer_if.slave  pif,
    output logic             busy_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [2:0] BR_LOAD    = 3'(BR_PENALTY);
    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYC - 1);

    logic [2:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       load_use;
    logic       pc_we, ifid_we, ifid_flush, idex_flush;

    // A load in EX whose destination is read by the instruction in ID
    assign load_use = pif.idex_read_mem_i &&
                      ((pif.idex_regD_i == pif.ifid_reg1_i) ||
                       (pif.ifid_uses_reg2_i && (pif.idex_regD_i == pif.ifid_reg2_i)));

    // Next-state, down-counter and pipeline control decode
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_we      = 1'b0;
        ifid_we    = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start_i) state_d = S_RUN;
            end
            S_RUN: begin
                if (pif.branch_taken_i) begin
                    // Fetch loads the target while both younger slots are squashed
                    pc_we   = 1'b1;
                    ifid_we = 1'b1;
                    if (BR_PENALTY > 0) begin
                        cnt_d   = BR_LOAD;
                        state_d = S_FLUSH;
                    end
                end else if (load_use) begin
                    // Hold PC and IF_ID, insert one bubble into ID_EX
                    ifid_flush = 1'b0;
                end else if (pif.ifid_halt_i) begin
                    // The halt cycle itself counts toward DRAIN_CYC, so DRAIN
                    // lasts DRAIN_CYC-1 cycles and is skipped when that is zero
                    ifid_flush = 1'b0;
                    cnt_d      = DRAIN_LOAD;
                    state_d    = (DRAIN_CYC <= 1) ? S_HALT : S_DRAIN;
                end else begin
                    pc_we      = 1'b1;
                    ifid_we    = 1'b1;
                    ifid_flush = 1'b0;
                    idex_flush = 1'b0;
                end
            end
            S_FLUSH: begin
                pc_we   = 1'b1;
                ifid_we = 1'b1;
                cnt_d   = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) state_d = S_RUN;
            end
            S_DRAIN: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State and down-counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pif.pc_we_o      = pc_we;
    assign pif.ifid_we_o    = ifid_we;
    assign pif.ifid_flush_o = ifid_flush;
    assign pif.idex_flush_o = idex_flush;
    assign busy_o   = (state_q == S_RUN) || (state_q == S_FLUSH) || (state_q == S_DRAIN);
    assign halted_o = (state_q == S_HALT);

`ifdef PIPE_SEQ_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             stall_inc, flush_inc, cnt_clear;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;

    assign cnt_clear = ((state_q == S_IDLE) || (state_q == S_HALT)) && start_i;
    assign flush_inc = (state_q == S_RUN) && pif.branch_taken_i;
    assign stall_inc = (state_q == S_RUN) && !pif.branch_taken_i && load_use;

    // Saturating counter update; a start request clears all three
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        if (cnt_clear) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
            cycle_cnt_d = '0;
        end else begin
            if (stall_inc && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
            if (flush_inc && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;
            if (busy_o    && (cycle_cnt_q != CNT_MAX)) cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign cycle_cnt_o = cycle_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
    assign cycle_cnt_o = '0;
`endif

endmodule
